pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined RISC-V core's fetch stage. It holds the architectural fetch PC and presents it to instruction memory over a valid/ready handshake. It applies stalls from the hazard unit, branch/jump redirects from EX and trap vectors in a fixed priority. It also detects misaligned redirect targets, parks in a fault state until a trap arrives, and counts accepted fetches.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_next_mux.sv | 37 +++
 rtl/pc_unit.sv | 86 ++++++++
 tb/tb_pc_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFault
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

    // Low PC bits that must be zero for a legal redirect target.
    function automatic logic [1:0] align_mask(input int unsigned ialign);
        return (ialign == 2) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority next-PC select (trap > redirect > stall > accept) with misaligned-target detect.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    input  logic            accept,
    input  logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_next,
    output logic            fault
);

    logic unused_trap_lsb;
    assign unused_trap_lsb = ^trap_vec[1:0];

    always_comb begin
        pc_next = pc_q;
        fault   = 1'b0;
        if (trap) begin
            pc_next = {trap_vec[XLEN-1:2], 2'b00};
        end else if (redirect) begin
            pc_next = redirect_pc;
            fault   = |(redirect_pc[1:0] & align_mask(IALIGN));
        end else if (stall) begin
            pc_next = pc_q;
        end else if (accept) begin
            pc_next = pc_q + XLEN'(PC_INC);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds the fetch PC, drives the imem request handshake,
// parks on misaligned redirects until a trap, and counts accepted fetches.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_pc,
    output logic [XLEN-1:0] fetch_count
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] misalign_pc_q;
    logic [XLEN-1:0] count_q;
    logic            in_run, redirect_eff, accept, redirect_fault, count_inc;

    assign in_run       = (state_q == StRun);
    // Redirects are only meaningful while running; BOOT and FAULT drop them.
    assign redirect_eff = redirect_valid && in_run;
    assign fetch_valid  = in_run && !stall;
    assign accept       = fetch_valid && fetch_ready;
    assign count_inc    = accept && !trap_valid && !redirect_eff;

    pc_next_mux #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_next_mux (
        .trap        (trap_valid),
        .trap_vec    (trap_vec),
        .redirect    (redirect_eff),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .accept      (accept),
        .pc_q        (pc_q),
        .pc_next     (pc_d),
        .fault       (redirect_fault)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (redirect_fault) state_d = StFault;
            StFault: if (trap_valid) state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_VECTOR;
            misalign_pc_q <= '0;
            count_q       <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (redirect_fault) begin
                misalign_pc_q <= redirect_pc;
            end
            if (count_inc) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign fetch_pc     = pc_q;
    assign misalign_err = (state_q == StFault);
    assign misalign_pc  = misalign_pc_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: accepted fetches are checked against a queue of
// expected (pc, count) pairs; status outputs are checked directly after each edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid, trap_valid, fetch_ready;
    logic [31:0] redirect_pc, trap_vec;
    logic        fetch_valid, misalign_err;
    logic [31:0] fetch_pc, misalign_pc, fetch_count;
    logic        fetch_valid2, misalign_err2;
    logic [31:0] fetch_pc2, misalign_pc2, fetch_count2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
    } acc_t;
    acc_t sb_q[$];

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .misalign_err   (misalign_err),
        .misalign_pc    (misalign_pc),
        .fetch_count    (fetch_count)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2)) dut2 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .fetch_valid    (fetch_valid2),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc2),
        .misalign_err   (misalign_err2),
        .misalign_pc    (misalign_pc2),
        .fetch_count    (fetch_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_accept(input logic [31:0] pc, input logic [31:0] cnt);
        sb_q.push_back('{pc: pc, cnt: cnt});
    endtask

    // Monitor: every handshake presented to imem must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && fetch_valid && fetch_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_accept actual_pc=0x%08h required=none", fetch_pc);
            end else begin
                acc_t e;
                e = sb_q.pop_front();
                chk("accept_pc", fetch_pc, e.pc);
                chk("accept_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        trap_valid = 1'b0; trap_vec = '0; fetch_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_mpc", misalign_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        // Boot then three back-to-back accepted fetches.
        rst = 1'b1;
        fetch_ready = 1'b1;
        #1;
        chk("boot_valid", {31'b0, fetch_valid}, 32'h0);
        expect_accept(32'h0, 32'd0);
        expect_accept(32'h4, 32'd1);
        expect_accept(32'h8, 32'd2);
        tick();
        chk("first_valid", {31'b0, fetch_valid}, 32'h1);
        chk("first_pc", fetch_pc, 32'h0);
        repeat (3) tick();
        fetch_ready = 1'b0;
        chk("seq_count", fetch_count, 32'd3);
        chk("seq_pc", fetch_pc, 32'hC);

        // Backpressure at pc 0x10.
        expect_accept(32'hC, 32'd3);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'b0, fetch_valid}, 32'h1);
            chk("bp_pc", fetch_pc, 32'h10);
        end
        expect_accept(32'h10, 32'd4);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("bp_next_pc", fetch_pc, 32'h14);
        chk("bp_count", fetch_count, 32'd5);

        // Redirect while stalled.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("stall_redir_pc", fetch_pc, 32'h100);
        chk("stall_valid", {31'b0, fetch_valid}, 32'h0);
        stall = 1'b0;
        #1;
        chk("unstall_valid", {31'b0, fetch_valid}, 32'h1);
        expect_accept(32'h100, 32'd5);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("redir_next_pc", fetch_pc, 32'h104);
        chk("redir_count", fetch_count, 32'd6);

        // Misaligned redirect: fault on IALIGN=4, legal on IALIGN=2.
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("fault_err", {31'b0, misalign_err}, 32'h1);
        chk("fault_mpc", misalign_pc, 32'h102);
        chk("fault_valid", {31'b0, fetch_valid}, 32'h0);
        chk("ialign2_err", {31'b0, misalign_err2}, 32'h0);
        chk("ialign2_pc", fetch_pc2, 32'h102);
        redirect_valid = 1'b1; redirect_pc = 32'h300; fetch_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        chk("fault_hold_err", {31'b0, misalign_err}, 32'h1);
        chk("fault_hold_pc", fetch_pc, 32'h102);
        chk("fault_hold_valid", {31'b0, fetch_valid}, 32'h0);
        chk("fault_hold_mpc", misalign_pc, 32'h102);
        trap_valid = 1'b1; trap_vec = 32'h203;
        tick();
        trap_valid = 1'b0;
        chk("trap_pc", fetch_pc, 32'h200);
        chk("trap_err", {31'b0, misalign_err}, 32'h0);
        chk("trap_valid_out", {31'b0, fetch_valid}, 32'h1);

        // Simultaneous trap + redirect + accept; then redirect + accept.
        trap_valid = 1'b1; trap_vec = 32'h80;
        redirect_valid = 1'b1; redirect_pc = 32'h40; fetch_ready = 1'b1;
        expect_accept(32'h200, 32'd6);
        tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0;
        chk("trap_wins_pc", fetch_pc, 32'h80);
        chk("trap_wins_count", fetch_count, 32'd6);
        redirect_valid = 1'b1; redirect_pc = 32'h40; fetch_ready = 1'b1;
        expect_accept(32'h80, 32'd6);
        tick();
        redirect_valid = 1'b0;
        chk("redir_wins_pc", fetch_pc, 32'h40);
        chk("redir_wins_count", fetch_count, 32'd6);
        expect_accept(32'h40, 32'd6);
        tick();
        fetch_ready = 1'b0;
        chk("post_redir_pc", fetch_pc, 32'h44);
        chk("post_redir_count", fetch_count, 32'd7);

        // PC wrap.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        expect_accept(32'hFFFF_FFFC, 32'd7);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("wrap_pc", fetch_pc, 32'h0);
        chk("wrap_count", fetch_count, 32'd8);

        // Asynchronous reset from FAULT.
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        chk("fault2_err", {31'b0, misalign_err}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("arst_pc", fetch_pc, 32'h0);
        chk("arst_err", {31'b0, misalign_err}, 32'h0);
        chk("arst_mpc", misalign_pc, 32'h0);
        chk("arst_count", fetch_count, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("reboot_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        chk("reboot_run_valid", {31'b0, fetch_valid}, 32'h1);
        chk("reboot_pc", fetch_pc, 32'h0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
